bus_responder: RTL and testbench
================================

// Module: bus_responder
// PURPOSE
// - Memory-side responder for the CPU bus opcodes (IDLE/IF/READ/WRITE, bus_opcode_t) issued by the control unit.
// - Latches opcode/address/write data, runs one handshaked access on the external memory port.
// - Returns the fetched opcode (next_opcode) or read byte (bus_din).
// - Asserts stall so the control unit holds its M-cycle until the access completes.
// PARAMETERS
// - TIMEOUT_CYCLES  15     max cycles in REQ before abort (1..255)
// - RESET_OPCODE    8'h00  next_opcode after reset (NOP)
// - ERR_DATA        8'hFF  byte returned on timeout
// PORTS
// - clk            in   1   clock
// - rst            in   1   synchronous active-high reset
// - bus_opcode_in  in   2   bus_opcode_t from control (IDLE, IF, READ, WRITE)
// - bus_addr       in   16  address (register-file rr read port)
// - bus_dout       in   8   CPU write data
// - stall          out  1   CPU must hold m_cycle while high
// - next_opcode    out  8   last fetched opcode, registered
// - bus_din        out  8   last READ data, registered
// - bus_err        out  1   sticky timeout flag
// - mem_req        out  1   access request, registered
// - mem_we         out  1   1 = write, registered
// - mem_addr       out  16  registered address
// - mem_wdata      out  8   registered write data
// - mem_rdata      in   8   read data, valid when mem_ack=1
// - mem_ack        in   1   one-cycle completion strobe
// BEHAVIOUR
// - Reset (sync, any state):
//   - State goes to IDLE_S at the edge. Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, bus_din=0, bus_err=0, next_opcode=RESET_OPCODE.
//   - stall is forced 0 while rst=1.
//   - An access in flight is abandoned. A late mem_ack after reset is ignored.
// - States: IDLE_S, REQ_S.
//   - IDLE_S, opcode!=IDLE: latch op/addr/dout. Drive mem_req=1, mem_we=(op==WRITE) from the next cycle. Go to REQ_S.
//   - IDLE_S, opcode==IDLE: no memory activity. The outputs hold.
//   - REQ_S: hold mem_req/mem_addr/mem_we/mem_wdata stable until mem_ack.
//   - REQ_S, mem_ack=1: capture the result at that edge. Drop mem_req. Return to IDLE_S.
//     - IF: next_opcode<=mem_rdata.
//     - READ: bus_din<=mem_rdata.
//     - WRITE: capture nothing.
// - stall (combinational) = (IDLE_S && op!=IDLE) || (REQ_S && !mem_ack).
// - Latency:
//   - Minimum 2 cycles per access (accept cycle plus ack cycle), with mem_ack in the first REQ_S cycle.
//   - Each wait cycle adds 1.
//   - Captured data is visible the cycle after the ack edge, and held until the next capture of the same kind.
// - Timeout:
//   - An 8-bit counter clears on entry to REQ_S and counts REQ_S cycles without ack.
//   - When the count reaches TIMEOUT_CYCLES, drop mem_req and write ERR_DATA to the IF/READ destination.
//   - At the same time set bus_err, release stall and return to IDLE_S.
//   - An ack arriving in the same cycle as the timeout wins (normal completion, bus_err not set).
// - Changes on bus_opcode_in/bus_addr/bus_dout during REQ_S are ignored; latched values are used.
// - mem_ack in IDLE_S is ignored.
// - Back-to-back: a new non-IDLE op in the cycle after completion is accepted normally. The minimum gap between mem_req pulses is 1 cycle.
// TESTING
// - Reset, then IF @0x0100 with ack in the 1st REQ cycle: mem_req 1 cycle, stall high 1 cycle, next_opcode=mem_rdata (0x3E), bus_din unchanged.
// - READ @0xC000 with ack after 3 waits: stall high 4 cycles. Addr/we stable during the access. bus_din=0x5A afterwards.
// - WRITE @0xFF80 with dout=0xA7: mem_we=1, mem_wdata=0xA7. bus_din/next_opcode unchanged. Change bus_addr mid-access: mem_addr stays 0xFF80.
// - READ with no ack: after 15 REQ cycles mem_req=0, bus_din=0xFF, bus_err=1, stall=0. bus_err persists until rst.
// - rst asserted in the 2nd REQ cycle: next edge mem_req=0, next_opcode=0x00. Later mem_ack is ignored, no capture.
// - IF/READ/IF back-to-back, plus IDLE cycles: no mem_req during IDLE, correct destinations updated, no lost ack.

Source files
------------

// File: rtl/bus_responder_if.sv
// Bus bundle between the control unit, the bus responder and the external memory port.
// The master side is the control unit plus the memory model; the slave side is the responder.
interface bus_responder_if;
  logic [1:0]  bus_opcode_in;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        stall;
  logic [7:0]  next_opcode;
  logic [7:0]  bus_din;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (
    output bus_opcode_in, bus_addr, bus_dout, mem_rdata, mem_ack,
    input  stall, next_opcode, bus_din, bus_err,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  bus_opcode_in, bus_addr, bus_dout, mem_rdata, mem_ack,
    output stall, next_opcode, bus_din, bus_err,
    output mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/bus_responder.sv
// Memory-side responder for CPU bus opcodes: runs one handshaked memory access per
// request, returns the fetched opcode or read byte, and stalls the CPU meanwhile.
module bus_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter logic [7:0]  RESET_OPCODE   = 8'h00,
  parameter logic [7:0]  ERR_DATA       = 8'hFF
) (
  input  logic            clk,
  input  logic            rst,
  bus_responder_if.slave  bus
);

  localparam logic [1:0] OP_IDLE  = 2'd0;
  localparam logic [1:0] OP_IF    = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_WRITE = 2'd3;

  // Timeout fires on the edge closing the TIMEOUT_CYCLES-th unacknowledged REQ cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE_S, REQ_S} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic [7:0]  next_opcode_q, next_opcode_d;
  logic [7:0]  bus_din_q, bus_din_d;
  logic        bus_err_q, bus_err_d;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    next_opcode_d = next_opcode_q;
    bus_din_d     = bus_din_q;
    bus_err_d     = bus_err_q;

    case (state_q)
      IDLE_S: begin
        if (bus.bus_opcode_in != OP_IDLE) begin
          state_d     = REQ_S;
          op_d        = bus.bus_opcode_in;
          cnt_d       = 8'd0;
          mem_req_d   = 1'b1;
          mem_we_d    = (bus.bus_opcode_in == OP_WRITE);
          mem_addr_d  = bus.bus_addr;
          mem_wdata_d = bus.bus_dout;
        end
      end
      REQ_S: begin
        // An ack in the timeout cycle still counts as a normal completion.
        if (bus.mem_ack) begin
          state_d   = IDLE_S;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          case (op_q)
            OP_IF:   next_opcode_d = bus.mem_rdata;
            OP_READ: bus_din_d     = bus.mem_rdata;
            default: ;
          endcase
        end else if (cnt_q == TO_LAST) begin
          state_d   = IDLE_S;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          bus_err_d = 1'b1;
          case (op_q)
            OP_IF:   next_opcode_d = ERR_DATA;
            OP_READ: bus_din_d     = ERR_DATA;
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE_S;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE_S;
      op_q          <= OP_IDLE;
      cnt_q         <= 8'd0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 16'h0000;
      mem_wdata_q   <= 8'h00;
      next_opcode_q <= RESET_OPCODE;
      bus_din_q     <= 8'h00;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      next_opcode_q <= next_opcode_d;
      bus_din_q     <= bus_din_d;
      bus_err_q     <= bus_err_d;
    end
  end

  // Stall covers the accept cycle and every unacknowledged REQ cycle; reset overrides it.
  assign bus.stall = !rst &&
                     (((state_q == IDLE_S) && (bus.bus_opcode_in != OP_IDLE)) ||
                      ((state_q == REQ_S) && !bus.mem_ack));

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.next_opcode = next_opcode_q;
  assign bus.bus_din     = bus_din_q;
  assign bus.bus_err     = bus_err_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: fetch, read with waits, write, timeout,
// reset mid-access, back-to-back traffic and ack-versus-timeout priority.
module tb_bus_responder;

  logic clk = 1'b0;
  logic rst;

  int total  = 0;
  int passed = 0;

  bus_responder_if bus_if ();

  bus_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to 1ns past the next rising edge; inputs are then driven for the coming cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] dout,
                       input logic ack, input logic [7:0] rdata);
    bus_if.bus_opcode_in = op;
    bus_if.bus_addr      = addr;
    bus_if.bus_dout      = dout;
    bus_if.mem_ack       = ack;
    bus_if.mem_rdata     = rdata;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus_if.bus_opcode_in = 2'd0;
    bus_if.bus_addr      = 16'h0000;
    bus_if.bus_dout      = 8'h00;
    bus_if.mem_ack       = 1'b0;
    bus_if.mem_rdata     = 8'h00;
    tick();
    tick();

    // Reset state; stall must stay low under reset even with a pending opcode
    drive(2'd1, 16'h0100, 8'h00, 1'b0, 8'h00);
    chk("rst_stall", 32'(bus_if.stall), 32'h0);
    chk("rst_mem_req", 32'(bus_if.mem_req), 32'h0);
    chk("rst_mem_we", 32'(bus_if.mem_we), 32'h0);
    chk("rst_mem_addr", 32'(bus_if.mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(bus_if.mem_wdata), 32'h0);
    chk("rst_bus_din", 32'(bus_if.bus_din), 32'h0);
    chk("rst_bus_err", 32'(bus_if.bus_err), 32'h0);
    chk("rst_next_opcode", 32'(bus_if.next_opcode), 32'h00);

    // IF @0x0100, ack in first REQ cycle
    rst = 1'b0;
    #1;
    chk("if_accept_stall", 32'(bus_if.stall), 32'h1);
    chk("if_accept_req", 32'(bus_if.mem_req), 32'h0);
    tick();
    drive(2'd0, 16'h0000, 8'h00, 1'b1, 8'h3E);
    chk("if_req", 32'(bus_if.mem_req), 32'h1);
    chk("if_addr", 32'(bus_if.mem_addr), 32'h0100);
    chk("if_we", 32'(bus_if.mem_we), 32'h0);
    chk("if_ack_stall", 32'(bus_if.stall), 32'h0);
    tick();
    drive(2'd0, 16'h0000, 8'h00, 1'b0, 8'h00);
    chk("if_done_req", 32'(bus_if.mem_req), 32'h0);
    chk("if_next_opcode", 32'(bus_if.next_opcode), 32'h3E);
    chk("if_bus_din_kept", 32'(bus_if.bus_din), 32'h00);
    chk("if_done_stall", 32'(bus_if.stall), 32'h0);

    // READ @0xC000, three wait cycles then ack; address change ignored
    drive(2'd2, 16'hC000, 8'h00, 1'b0, 8'h00);
    chk("rd_stall_1", 32'(bus_if.stall), 32'h1);
    tick();
    drive(2'd0, 16'h1234, 8'h00, 1'b0, 8'h00);
    chk("rd_stall_2", 32'(bus_if.stall), 32'h1);
    chk("rd_req", 32'(bus_if.mem_req), 32'h1);
    chk("rd_addr_2", 32'(bus_if.mem_addr), 32'hC000);
    chk("rd_we", 32'(bus_if.mem_we), 32'h0);
    tick();
    chk("rd_stall_3", 32'(bus_if.stall), 32'h1);
    chk("rd_addr_3", 32'(bus_if.mem_addr), 32'hC000);
    tick();
    chk("rd_stall_4", 32'(bus_if.stall), 32'h1);
    chk("rd_req_4", 32'(bus_if.mem_req), 32'h1);
    tick();
    drive(2'd0, 16'h1234, 8'h00, 1'b1, 8'h5A);
    chk("rd_ack_stall", 32'(bus_if.stall), 32'h0);
    chk("rd_addr_ack", 32'(bus_if.mem_addr), 32'hC000);
    tick();
    drive(2'd0, 16'h0000, 8'h00, 1'b0, 8'h00);
    chk("rd_bus_din", 32'(bus_if.bus_din), 32'h5A);
    chk("rd_next_opcode_kept", 32'(bus_if.next_opcode), 32'h3E);
    chk("rd_done_req", 32'(bus_if.mem_req), 32'h0);

    // WRITE @0xFF80 with 0xA7; bus inputs change mid-access
    drive(2'd3, 16'hFF80, 8'hA7, 1'b0, 8'h00);
    chk("wr_accept_stall", 32'(bus_if.stall), 32'h1);
    tick();
    drive(2'd0, 16'h0000, 8'h00, 1'b0, 8'h00);
    chk("wr_req", 32'(bus_if.mem_req), 32'h1);
    chk("wr_we", 32'(bus_if.mem_we), 32'h1);
    chk("wr_wdata", 32'(bus_if.mem_wdata), 32'hA7);
    chk("wr_addr", 32'(bus_if.mem_addr), 32'hFF80);
    tick();
    drive(2'd0, 16'h0000, 8'h00, 1'b1, 8'h11);
    chk("wr_addr_hold", 32'(bus_if.mem_addr), 32'hFF80);
    chk("wr_wdata_hold", 32'(bus_if.mem_wdata), 32'hA7);
    chk("wr_ack_stall", 32'(bus_if.stall), 32'h0);
    tick();
    drive(2'd0, 16'h0000, 8'h00, 1'b0, 8'h00);
    chk("wr_bus_din_kept", 32'(bus_if.bus_din), 32'h5A);
    chk("wr_next_opcode_kept", 32'(bus_if.next_opcode), 32'h3E);
    chk("wr_done_req", 32'(bus_if.mem_req), 32'h0);
    chk("wr_bus_err", 32'(bus_if.bus_err), 32'h0);

    // READ with no ack: timeout after 15 REQ cycles
    drive(2'd2, 16'h2000, 8'h00, 1'b0, 8'h00);
    tick();
    drive(2'd0, 16'h0000, 8'h00, 1'b0, 8'h00);
    chk("to_req_1", 32'(bus_if.mem_req), 32'h1);
    for (int i = 2; i <= 15; i++) begin
      tick();
      chk($sformatf("to_req_%0d", i), 32'(bus_if.mem_req), 32'h1);
    end
    chk("to_stall_15", 32'(bus_if.stall), 32'h1);
    tick();
    chk("to_req_dropped", 32'(bus_if.mem_req), 32'h0);
    chk("to_bus_din", 32'(bus_if.bus_din), 32'hFF);
    chk("to_bus_err", 32'(bus_if.bus_err), 32'h1);
    chk("to_stall", 32'(bus_if.stall), 32'h0);
    tick();
    tick();
    chk("to_bus_err_sticky", 32'(bus_if.bus_err), 32'h1);

    // Reset asserted in the second REQ cycle of an IF; late ack ignored
    drive(2'd1, 16'h0200, 8'h00, 1'b0, 8'h00);
    tick();
    drive(2'd0, 16'h0000, 8'h00, 1'b0, 8'h00);
    tick();
    rst = 1'b1;
    #1;
    chk("mr_stall_forced", 32'(bus_if.stall), 32'h0);
    tick();
    chk("mr_req", 32'(bus_if.mem_req), 32'h0);
    chk("mr_next_opcode", 32'(bus_if.next_opcode), 32'h00);
    chk("mr_bus_err", 32'(bus_if.bus_err), 32'h0);
    chk("mr_bus_din", 32'(bus_if.bus_din), 32'h00);
    rst = 1'b0;
    drive(2'd0, 16'h0000, 8'h00, 1'b1, 8'h77);
    tick();
    drive(2'd0, 16'h0000, 8'h00, 1'b0, 8'h00);
    chk("mr_late_ack_opcode", 32'(bus_if.next_opcode), 32'h00);
    chk("mr_late_ack_din", 32'(bus_if.bus_din), 32'h00);
    chk("mr_late_ack_req", 32'(bus_if.mem_req), 32'h0);

    // Back-to-back IF / READ / IF, then idle cycles with a stray ack
    drive(2'd1, 16'h0300, 8'h00, 1'b0, 8'h00);
    chk("bb_if1_stall", 32'(bus_if.stall), 32'h1);
    tick();
    drive(2'd2, 16'h0400, 8'h00, 1'b1, 8'hC3);
    chk("bb_if1_addr", 32'(bus_if.mem_addr), 32'h0300);
    chk("bb_if1_ack_stall", 32'(bus_if.stall), 32'h0);
    tick();
    drive(2'd2, 16'h0400, 8'h00, 1'b0, 8'h00);
    chk("bb_if1_opcode", 32'(bus_if.next_opcode), 32'hC3);
    chk("bb_gap_req", 32'(bus_if.mem_req), 32'h0);
    chk("bb_rd_accept_stall", 32'(bus_if.stall), 32'h1);
    tick();
    drive(2'd1, 16'h0500, 8'h00, 1'b1, 8'h5C);
    chk("bb_rd_req", 32'(bus_if.mem_req), 32'h1);
    chk("bb_rd_addr", 32'(bus_if.mem_addr), 32'h0400);
    tick();
    drive(2'd1, 16'h0500, 8'h00, 1'b0, 8'h00);
    chk("bb_rd_din", 32'(bus_if.bus_din), 32'h5C);
    chk("bb_rd_opcode_kept", 32'(bus_if.next_opcode), 32'hC3);
    chk("bb_if2_accept_stall", 32'(bus_if.stall), 32'h1);
    tick();
    drive(2'd0, 16'h0000, 8'h00, 1'b0, 8'h00);
    chk("bb_if2_addr", 32'(bus_if.mem_addr), 32'h0500);
    chk("bb_if2_wait_stall", 32'(bus_if.stall), 32'h1);
    tick();
    drive(2'd0, 16'h0000, 8'h00, 1'b1, 8'hE9);
    tick();
    drive(2'd0, 16'h0000, 8'h00, 1'b1, 8'h12);
    chk("bb_if2_opcode", 32'(bus_if.next_opcode), 32'hE9);
    chk("bb_if2_din_kept", 32'(bus_if.bus_din), 32'h5C);
    chk("bb_idle_req", 32'(bus_if.mem_req), 32'h0);
    tick();
    drive(2'd0, 16'h0000, 8'h00, 1'b0, 8'h00);
    chk("bb_idle_ack_ignored", 32'(bus_if.next_opcode), 32'hE9);
    chk("bb_idle_req_2", 32'(bus_if.mem_req), 32'h0);
    chk("bb_idle_stall", 32'(bus_if.stall), 32'h0);

    // READ with ack in the 15th REQ cycle: ack beats timeout
    drive(2'd2, 16'h0600, 8'h00, 1'b0, 8'h00);
    tick();
    drive(2'd0, 16'h0000, 8'h00, 1'b0, 8'h00);
    for (int i = 2; i <= 15; i++) tick();
    drive(2'd0, 16'h0000, 8'h00, 1'b1, 8'h42);
    chk("race_req_15", 32'(bus_if.mem_req), 32'h1);
    tick();
    drive(2'd0, 16'h0000, 8'h00, 1'b0, 8'h00);
    chk("race_bus_din", 32'(bus_if.bus_din), 32'h42);
    chk("race_bus_err", 32'(bus_if.bus_err), 32'h0);
    chk("race_req_dropped", 32'(bus_if.mem_req), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
